// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with HI/LO result registers.
// 32 shift-add / restoring iterations, a FIX cycle for sign correction, then DONE.
// Fixed latency for every op: start sampled at edge N, done visible after edge N+33.
// Optional feature: define MULT_DIV_SIGNED_EN to make op[0]=1 select signed mult/div.
module mult_div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_by_zero
);

    localparam int unsigned ACC_W = 2 * DATA_W;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [DATA_W-1:0]  opnd;
    logic [DATA_W-1:0]  rs_orig;
    logic               is_div;
    logic               accept_c;

    logic [DATA_W-1:0]  rs_mag_c;
    logic [DATA_W-1:0]  rt_mag_c;
    logic [DATA_W:0]    mul_sum_c;
    logic [ACC_W-1:0]   mul_nx_c;
    logic [DATA_W:0]    div_r_c;
    logic [DATA_W:0]    div_diff_c;
    logic               div_ge_c;
    logic [ACC_W-1:0]   div_nx_c;
    logic [DATA_W-1:0]  fix_hi_c;
    logic [DATA_W-1:0]  fix_lo_c;
    logic               div_zero_c;

`ifdef MULT_DIV_SIGNED_EN
    logic               signed_c;
    logic               neg_lo_c;
    logic               neg_hi_c;
    logic               neg_lo;
    logic               neg_hi;
    logic [ACC_W-1:0]   neg_acc_c;
`else
    logic               unused_op0;
`endif

    assign accept_c   = start && ((state == S_IDLE) || (state == S_DONE));
    assign div_zero_c = is_div && (opnd == '0);

    // Operand magnitudes at capture; signed ops iterate on absolute values.
`ifdef MULT_DIV_SIGNED_EN
    always_comb begin
        signed_c = op[0];
        rs_mag_c = (signed_c && rs_val[DATA_W-1]) ? -rs_val : rs_val;
        rt_mag_c = (signed_c && rt_val[DATA_W-1]) ? -rt_val : rt_val;
        neg_lo_c = signed_c && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
        neg_hi_c = signed_c && rs_val[DATA_W-1];
    end
`else
    always_comb begin
        rs_mag_c   = rs_val;
        rt_mag_c   = rt_val;
        unused_op0 = op[0];
    end
`endif

    // One iteration step: shift-add multiply and restoring divide.
    always_comb begin
        mul_sum_c  = {1'b0, acc[ACC_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nx_c   = {mul_sum_c, acc[DATA_W-1:1]};
        div_r_c    = {acc[ACC_W-1:DATA_W], acc[DATA_W-1]};
        div_ge_c   = (div_r_c >= {1'b0, opnd});
        div_diff_c = div_r_c - {1'b0, opnd};
        div_nx_c   = {(div_ge_c ? div_diff_c[DATA_W-1:0] : div_r_c[DATA_W-1:0]),
                      acc[DATA_W-2:0], div_ge_c};
    end

    // FIX-cycle result: sign correction and divide-by-zero override.
    always_comb begin
        fix_hi_c = acc[ACC_W-1:DATA_W];
        fix_lo_c = acc[DATA_W-1:0];
`ifdef MULT_DIV_SIGNED_EN
        neg_acc_c = -acc;
        if (is_div) begin
            if (neg_lo) fix_lo_c = -acc[DATA_W-1:0];
            if (neg_hi) fix_hi_c = -acc[ACC_W-1:DATA_W];
        end else if (neg_lo) begin
            fix_hi_c = neg_acc_c[ACC_W-1:DATA_W];
            fix_lo_c = neg_acc_c[DATA_W-1:0];
        end
`endif
        if (div_zero_c) begin
            fix_lo_c = '1;
            fix_hi_c = rs_orig;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_ITER;
            S_ITER:  if (cnt == CNT_LAST) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_ITER : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration counter and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            rs_orig <= '0;
            is_div  <= 1'b0;
`ifdef MULT_DIV_SIGNED_EN
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
`endif
        end else if (accept_c) begin
            cnt     <= '0;
            is_div  <= op[1];
            rs_orig <= rs_val;
`ifdef MULT_DIV_SIGNED_EN
            neg_lo  <= neg_lo_c;
            neg_hi  <= neg_hi_c;
`endif
            if (op[1]) begin
                acc  <= {{DATA_W{1'b0}}, rs_mag_c};
                opnd <= rt_mag_c;
            end else begin
                acc  <= {{DATA_W{1'b0}}, rt_mag_c};
                opnd <= rs_mag_c;
            end
        end else if (state == S_ITER) begin
            cnt <= cnt + CNT_W'(1);
            acc <= is_div ? div_nx_c : mul_nx_c;
        end
    end

    // Registered outputs; hi/lo load on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_nx == S_ITER) || (state_nx == S_FIX);
            done <= (state_nx == S_DONE);
            if (state == S_FIX) begin
                hi          <= fix_hi_c;
                lo          <= fix_lo_c;
                div_by_zero <= div_zero_c;
            end else if (accept_c) begin
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic [31:0] due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          rst_seen = 1'b1;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    mult_div_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Reference model from plain arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] due);
        exp_t        e;
        longint      sa, sb, p, qq, rr;
        logic [63:0] up;
        bit          sgn;
        sgn = 1'b0;
`ifdef MULT_DIV_SIGNED_EN
        sgn = o[0];
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.due = due;
        e.dbz = 1'b0;
        if (!o[1]) begin
            if (sgn) begin
                p = sa * sb;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end else begin
                up = {32'b0, a} * {32'b0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
        end else if (b == 32'd0) begin
            e.lo  = 32'hFFFF_FFFF;
            e.hi  = a;
            e.dbz = 1'b1;
        end else if (sgn) begin
            qq = sa / sb;
            rr = sa % sb;
            e.lo = qq[31:0];
            e.hi = rr[31:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Monitor: result check on done, hi/lo hold check otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done at cyc %0d: hi=%h lo=%h, required no done", cyc, hi, lo);
            end else begin
                e = q.pop_front();
                if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz || cyc != e.due || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL result: got hi=%h lo=%h dbz=%b cyc=%0d busy=%b, required hi=%h lo=%h dbz=%b cyc=%0d busy=0",
                             hi, lo, div_by_zero, cyc, busy, e.hi, e.lo, e.dbz, e.due);
                end
            end
        end else if (!rst_seen) begin
            checks++;
            if (hi !== prev_hi || lo !== prev_lo) begin
                errors++;
                $display("FAIL hold: hi/lo changed outside DONE to %h/%h, required %h/%h", hi, lo, prev_hi, prev_lo);
            end
        end
        prev_hi = hi;
        prev_lo = lo;
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Wait (bounded) for busy=0, then present one start pulse.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input int gap);
        int guard;
        repeat (gap) @(negedge clk);
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy=%b, required 0", busy);
        end
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        if (push) q.push_back(model(o, a, b, cyc + 34));
        @(negedge clk);
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        checks++;
        if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept: dbz=%b busy=%b, required dbz=0 busy=1", div_by_zero, busy);
        end
    endtask

    initial begin
        int bad;
        int dones;
        int guard;
        rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h dbz=%b, required all 0",
                     busy, done, hi, lo, div_by_zero);
        end
        // start presented during reset is discarded
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_reset: busy=%b, required 0", busy);
        end

        // multu full-range product with busy window check
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        bad = 0;
        for (int k = 1; k <= 33; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (k < 33) @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL busy_window: %0d cycles off, required busy=1 done=0 in cycles 1-33", bad);
        end

        issue(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b1, 0);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        issue(2'b10, 32'd100, 32'd7, 1'b1, 0);
        issue(2'b10, 32'h0000_1234, 32'd0, 1'b1, 2);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        issue(2'b11, 32'hFFFF_FF00, 32'd0, 1'b1, 0);

        // second start at cycle 5 is ignored
        issue(2'b01, 32'h1234_5678, 32'h8765_4321, 1'b1, 1);
        repeat (4) @(negedge clk);
        op = 2'b10; rs_val = 32'd9; rt_val = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // reset at cycle 10 aborts with no done
        issue(2'b00, 32'hDEAD_BEEF, 32'h0000_0003, 1'b0, 0);
        repeat (9) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: hi=%h lo=%h busy=%b, required 0 0 0", hi, lo, busy);
        end
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: dones=%0d busy=%b, required 0 0", dones, busy);
        end

        // randomized ops, mixing back-to-back and idle gaps
        for (int i = 0; i < 40; i++)
            issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b1, int'($urandom_range(0, 2)));

        guard = 0;
        while ((q.size() != 0 || busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
